hex_entry_controller: RTL
=========================

Name: hex_entry_controller

Overview:
- Sequences operator entry of a 4-digit hex value from 4 slide switches into a 16-bit word.
- Three raw push-buttons drive it: load digit, backspace, and commit.
- It debounces the buttons, edge-detects them, and shifts nibbles into a working register with a digit count.
- It transfers the working value to the committed output register on commit. It sits between board I/O and the display/datapath that consumes the 16-bit value.

Parameters:
- DB_CYCLES, 16'd50000, number of consecutive clk cycles a synchronized button level must be stable before it is accepted (sim benches use 4).
- DB_W, 16, width of the debounce counter; must hold DB_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- In  input  4  hex digit from switches, sampled on an accepted load press.
- load  input  1  raw load-digit button, active-high, asynchronous to clk.
- bksp  input  1  raw backspace button, active-high.
- commit  input  1  raw commit button, active-high.
- entry  output  16  working value; the newest digit is in [3:0].
- Out  output  16  last committed value.
- count  output  3  digits currently in entry (0..4).
- full  output  1  high when count==4.
- done  output  1  one-cycle pulse on the cycle Out is updated.
- ovf  output  1  sticky flag: a load was pressed while full; cleared by commit or reset.

Behaviour:
- Reset (async, active-high): entry=0, Out=0, count=0, full=0, done=0, ovf=0, all synchronizer/debounce/edge state=0, FSM=EMPTY. Reset mid-debounce or mid-entry discards everything.
- Input conditioning, per button, identical for load/bksp/commit:
  - 2-flop synchronizer.
  - Debounce: a counter resets whenever the synchronized level differs from the stable level. When the counter reaches DB_CYCLES-1 with the level still different, the stable level updates.
  - Rising edge of the stable level = one-cycle press pulse (p_load, p_bksp, p_commit).
  - Latency from a clean raw edge to the pulse: 2 sync cycles + DB_CYCLES + 1 edge-register cycle. The action takes effect on the next clk edge.
  - Releases and glitches shorter than DB_CYCLES produce no pulse. Holding a button produces exactly one pulse.
- Priority when pulses coincide in one cycle: commit > bksp > load. Lower-priority pulses in that cycle are dropped, not queued.
- FSM states: EMPTY (count==0), PARTIAL (1..3), FULL (4). The state is derived from count; count is the only state register.
- Load pulse:
  - Not FULL: entry <= {entry[11:0], In}, count+1. In is sampled on the same cycle as the pulse.
  - FULL: entry and count unchanged; ovf <= 1.
- Bksp pulse:
  - count>0: entry <= {4'h0, entry[15:4]}, count-1.
  - EMPTY: no effect.
- Commit pulse:
  - count>0: Out <= entry (the unentered upper digits are already zero), done=1 for exactly that cycle, entry <= 0, count <= 0, ovf <= 0.
  - EMPTY: no effect, no done.
- full is combinational from count (count==4). done is a registered pulse aligned with the Out update.
- Out holds its value across all load/bksp activity until the next accepted commit.
- count never exceeds 4 and never wraps below 0.

Test Plan (DB_CYCLES=4):
- Reset, then load presses with In=1,2,3,4 → entry steps 0001, 0012, 0123, 1234; count=4; full=1; Out=0000; no done.
- From that state, one more load with In=F → entry=1234 unchanged, ovf=1. Then commit → Out=1234, done high exactly 1 cycle, entry=0, count=0, ovf=0.
- Load A, load B, bksp, load C, commit → Out=00AC, done pulse. Bksp or commit while EMPTY → no change, no done.
- Raw load glitch of 2 cycles, then a bouncing press (3 toggles of 1-2 cycles, then stable 20 cycles) → exactly one digit accepted; no digit from the glitch.
- Stable load and commit presses aligned to produce pulses in the same cycle, with count=2 → commit wins: Out=previous entry, count=0, load digit dropped.
- Assert reset mid-entry (count=3) and while a button is held → all outputs 0 immediately. After release with the button still held, no pulse until it is released and pressed again.

Source files
------------

// File: rtl/hex_entry_if.sv
// Operator-facing bundle for the hex entry controller:
// raw buttons and switch digit in, working/committed values out.
interface hex_entry_if;
  logic [3:0]  In;
  logic        load;
  logic        bksp;
  logic        commit;
  logic [15:0] entry;
  logic [15:0] Out;
  logic [2:0]  count;
  logic        full;
  logic        done;
  logic        ovf;

  modport master (
    output In, load, bksp, commit,
    input  entry, Out, count, full, done, ovf
  );

  modport slave (
    input  In, load, bksp, commit,
    output entry, Out, count, full, done, ovf
  );
endinterface

// File: rtl/hex_entry_controller.sv
// Debounced 4-digit hex entry: load/backspace/commit buttons shift
// switch nibbles into a working word and commit it to Out.
module hex_entry_controller #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned DB_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  hex_entry_if.slave bus
);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  logic [2:0]      raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      stable;
  logic [2:0]      stable_d;
  logic [2:0]      armed;
  logic [2:0]      pulse;
  logic [2:0]      act;
  logic [DB_W-1:0] cnt [3];

  logic [15:0] entry_q;
  logic [15:0] out_q;
  logic [2:0]  count_q;
  logic        done_q;
  logic        ovf_q;
  state_t      state;

  assign raw = {bus.commit, bus.bksp, bus.load};

  // A button only arms once its synchronized level has been seen low
  // for a full debounce window, so a press held through reset never
  // fires until it is released and pressed again. DB_CYCLES must
  // exceed the 2-cycle synchronizer fill after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_d <= '0;
      armed    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (!armed[i]) begin
          if (s2[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == DB_LAST) begin
            armed[i] <= 1'b1;
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + DB_W'(1);
          end
        end else if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign pulse = stable & ~stable_d;

  // Resolve coincident presses to one action: commit > bksp > load.
  assign act[2] = pulse[2];
  assign act[1] = pulse[1] & ~pulse[2];
  assign act[0] = pulse[0] & ~pulse[1] & ~pulse[2];

  always_comb begin
    state = PARTIAL;
    if (count_q == 3'd0)      state = EMPTY;
    else if (count_q == 3'd4) state = FULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      out_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        act[2]: begin
          if (state != EMPTY) begin
            out_q   <= entry_q;
            done_q  <= 1'b1;
            entry_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        act[1]: begin
          if (state != EMPTY) begin
            entry_q <= {4'h0, entry_q[15:4]};
            count_q <= count_q - 3'd1;
          end
        end
        act[0]: begin
          if (state == FULL) begin
            ovf_q <= 1'b1;
          end else begin
            entry_q <= {entry_q[11:0], bus.In};
            count_q <= count_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.entry = entry_q;
  assign bus.Out   = out_q;
  assign bus.count = count_q;
  assign bus.full  = (count_q == 3'd4);
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
endmodule
